// File: rtl/cache_ctrl_pkg.sv
// Shared widths, cache-word field layout and FSM state encoding for the
// direct-mapped write-back cache controller.
package cache_ctrl_pkg;

  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 8;
  localparam int IDX_W   = 2;
  localparam int TAG_W   = ADDR_W - IDX_W;
  localparam int LINE_W  = DATA_W + TAG_W + 2;

  // Cache word layout: {valid, dirty, tag, data}
  localparam int VALID_B = LINE_W - 1;
  localparam int DIRTY_B = LINE_W - 2;
  localparam int TAG_HI  = DATA_W + TAG_W - 1;
  localparam int TAG_LO  = DATA_W;

  localparam logic [IDX_W-1:0] IDX_LAST = '1;

  typedef enum logic [3:0] {
    S_INIT,
    S_IDLE,
    S_LOOKUP,
    S_COMPARE,
    S_WB,
    S_FILL,
    S_CINS,
    S_CWR,
    S_DONE,
    S_F_READ,
    S_F_CHECK,
    S_F_WB,
    S_F_CLEAN
  } state_t;

  function automatic logic [LINE_W-1:0] make_line(input logic             valid,
                                                  input logic             dirty,
                                                  input logic [TAG_W-1:0] tag,
                                                  input logic [DATA_W-1:0] data);
    return {valid, dirty, tag, data};
  endfunction

endpackage

// File: rtl/cache_ctrl_if.sv
// Requester-side bus of the cache controller: access handshake plus flush.
interface cache_ctrl_if;
  import cache_ctrl_pkg::*;

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              flush;
  logic              ready;
  logic              ack;
  logic [DATA_W-1:0] rdata;
  logic              flush_done;

  modport master (output req, we, addr, wdata, flush,
                  input  ready, ack, rdata, flush_done);

  modport slave  (input  req, we, addr, wdata, flush,
                  output ready, ack, rdata, flush_done);

endinterface

// File: rtl/cache_ctrl.sv
// Sequencer for a direct-mapped, write-back, write-allocate cache with 1-byte
// lines; drives the cache line macro and the RAM macro from one registered FSM.
module cache_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  cache_ctrl_if.slave       bus,
  output logic [IDX_W-1:0]  cache_addr,
  output logic [LINE_W-1:0] cache_data,
  output logic              cache_wren,
  input  logic [LINE_W-1:0] cache_q,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  localparam int WAIT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_LAT - 1);

  state_t              state;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [WAIT_W-1:0]   wait_cnt;

  logic [TAG_W-1:0]    tag_q;
  logic [TAG_W-1:0]    line_tag;
  logic [DATA_W-1:0]   line_data;
  logic                line_hit;
  logic                line_dirty;

  assign tag_q      = addr_q[ADDR_W-1:IDX_W];
  assign line_tag   = cache_q[TAG_HI:TAG_LO];
  assign line_data  = cache_q[DATA_W-1:0];
  assign line_hit   = cache_q[VALID_B] && (line_tag == tag_q);
  assign line_dirty = cache_q[VALID_B] && cache_q[DIRTY_B];

  // The line index lives in cache_addr for the whole op, so INIT and FLUSH use it as their counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= S_INIT;
      bus.ready      <= 1'b0;
      bus.ack        <= 1'b0;
      bus.rdata      <= '0;
      bus.flush_done <= 1'b0;
      cache_addr     <= '0;
      cache_data     <= '0;
      cache_wren     <= 1'b0;
      mem_addr       <= '0;
      mem_data       <= '0;
      mem_wren       <= 1'b0;
      we_q           <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      wait_cnt       <= '0;
    end else begin
      case (state)
        S_INIT: begin
          cache_data <= '0;
          cache_wren <= 1'b1;
          if (cache_wren && cache_addr == IDX_LAST) begin
            cache_wren <= 1'b0;
            bus.ready  <= 1'b1;
            state      <= S_IDLE;
          end else if (cache_wren) begin
            cache_addr <= cache_addr + IDX_W'(1);
          end else begin
            cache_addr <= '0;
          end
        end

        S_IDLE: begin
          if (bus.req) begin
            we_q       <= bus.we;
            addr_q     <= bus.addr;
            wdata_q    <= bus.wdata;
            cache_addr <= bus.addr[IDX_W-1:0];
            bus.ready  <= 1'b0;
            state      <= S_LOOKUP;
          end else if (bus.flush) begin
            cache_addr <= '0;
            bus.ready  <= 1'b0;
            state      <= S_F_READ;
          end
        end

        S_LOOKUP: state <= S_COMPARE;

        S_COMPARE: begin
          if (line_hit && !we_q) begin
            bus.rdata <= line_data;
            bus.ack   <= 1'b1;
            state     <= S_DONE;
          end else if (!line_hit && line_dirty) begin
            mem_addr <= {line_tag, cache_addr};
            mem_data <= line_data;
            mem_wren <= 1'b1;
            state    <= S_WB;
          end else if (we_q) begin
            cache_data <= make_line(1'b1, 1'b1, tag_q, wdata_q);
            cache_wren <= 1'b1;
            state      <= S_CWR;
          end else begin
            mem_addr <= addr_q;
            wait_cnt <= '0;
            state    <= S_FILL;
          end
        end

        S_WB: begin
          mem_wren <= 1'b0;
          if (we_q) begin
            cache_data <= make_line(1'b1, 1'b1, tag_q, wdata_q);
            cache_wren <= 1'b1;
            state      <= S_CWR;
          end else begin
            mem_addr <= addr_q;
            wait_cnt <= '0;
            state    <= S_FILL;
          end
        end

        S_FILL: begin
          if (wait_cnt == WAIT_LAST) begin
            cache_data <= make_line(1'b1, 1'b0, tag_q, mem_q);
            cache_wren <= 1'b1;
            state      <= S_CINS;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        S_CINS: begin
          cache_wren <= 1'b0;
          bus.rdata  <= cache_data[DATA_W-1:0];
          bus.ack    <= 1'b1;
          state      <= S_DONE;
        end

        S_CWR: begin
          cache_wren <= 1'b0;
          bus.ack    <= 1'b1;
          state      <= S_DONE;
        end

        S_DONE: begin
          bus.ack        <= 1'b0;
          bus.flush_done <= 1'b0;
          bus.ready      <= 1'b1;
          state          <= S_IDLE;
        end

        S_F_READ: state <= S_F_CHECK;

        // Clean lines are skipped; a dirty line costs one RAM write plus one cache write.
        S_F_CHECK: begin
          if (line_dirty) begin
            mem_addr   <= {line_tag, cache_addr};
            mem_data   <= line_data;
            mem_wren   <= 1'b1;
            cache_data <= make_line(1'b1, 1'b0, line_tag, line_data);
            state      <= S_F_WB;
          end else if (cache_addr == IDX_LAST) begin
            bus.flush_done <= 1'b1;
            state          <= S_DONE;
          end else begin
            cache_addr <= cache_addr + IDX_W'(1);
            state      <= S_F_READ;
          end
        end

        S_F_WB: begin
          mem_wren   <= 1'b0;
          cache_wren <= 1'b1;
          state      <= S_F_CLEAN;
        end

        S_F_CLEAN: begin
          cache_wren <= 1'b0;
          if (cache_addr == IDX_LAST) begin
            bus.flush_done <= 1'b1;
            state          <= S_DONE;
          end else begin
            cache_addr <= cache_addr + IDX_W'(1);
            state      <= S_F_READ;
          end
        end

        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed-vector bench for cache_ctrl: behavioural cache/RAM macros, a
// scoreboard of expected ack/flush_done responses and a decoupled monitor.
module tb_cache_ctrl;
  import cache_ctrl_pkg::*;

  localparam int MEM_LAT = 1;

  typedef struct {
    bit         kind;
    bit         chk;
    logic [7:0] rdata;
    int         lat;
  } exp_t;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [IDX_W-1:0]  cache_addr;
  logic [LINE_W-1:0] cache_data;
  logic              cache_wren;
  logic [LINE_W-1:0] cache_q;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_q;

  logic [LINE_W-1:0] lines [4];
  logic [DATA_W-1:0] ram   [32];
  bit                loaded = 1'b0;

  int   cyc        = 0;
  int   acc_cyc    = 0;
  int   mem_wr_cnt = 0;
  int   vectors    = 0;
  int   errors     = 0;
  exp_t sb[$];

  cache_ctrl_if bus();

  cache_ctrl #(.MEM_LAT(MEM_LAT)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .cache_addr (cache_addr),
    .cache_data (cache_data),
    .cache_wren (cache_wren),
    .cache_q    (cache_q),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_wren   (mem_wren),
    .mem_q      (mem_q)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Cache macro: synchronous read, one cycle; RAM: read data sampled MEM_LAT edges after the address.
  always @(posedge clock) begin
    if (!loaded) begin
      for (int i = 0; i < 32; i++) ram[i] <= 8'(8'h10 + i);
      ram[5] <= 8'hA5;
      ram[9] <= 8'h5A;
      for (int i = 0; i < 4; i++) lines[i] <= 13'h1FFF;
      loaded <= 1'b1;
    end else begin
      if (cache_wren) lines[cache_addr] <= cache_data;
      cache_q <= lines[cache_addr];
      if (mem_wren) begin
        ram[mem_addr] <= mem_data;
        if (!reset) mem_wr_cnt <= mem_wr_cnt + 1;
      end
    end
  end

  assign mem_q = ram[mem_addr];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every ack/flush_done pops one scoreboard entry; latency counts from the accepting IDLE cycle.
  always @(negedge clock) begin
    if (!reset) begin
      if (cache_wren || mem_wren) check_output("wren_exclusive", {31'd0, cache_wren & mem_wren}, 32'd0);
      if (bus.ack || bus.flush_done) begin
        if (sb.size() == 0) begin
          check_output("spurious_done", {30'd0, bus.ack, bus.flush_done}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_output("done_kind", {30'd0, bus.ack, bus.flush_done}, e.kind ? 32'd1 : 32'd2);
          if (e.chk) check_output("rdata", bus.rdata, e.rdata);
          check_output("latency", cyc - acc_cyc, e.lat);
        end
      end
    end
  end

  task automatic wait_accept();
    int n = 0;
    while (!bus.ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!bus.ready) check_output("accept_timeout", 32'd0, 32'd1);
    acc_cyc = cyc;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0) begin
      check_output("done_timeout", sb.size(), 32'd0);
      sb.delete();
    end
    @(negedge clock);
  endtask

  task automatic apply_stimulus(input logic w, input logic [4:0] a, input logic [7:0] d,
                                input logic [7:0] exp_rd, input int lat, input int exp_wr);
    exp_t e;
    int   wr0;
    e.kind  = 1'b0;
    e.chk   = !w;
    e.rdata = exp_rd;
    e.lat   = lat;
    sb.push_back(e);
    wr0 = mem_wr_cnt;
    bus.req   = 1'b1;
    bus.we    = w;
    bus.addr  = a;
    bus.wdata = d;
    wait_accept();
    @(negedge clock);
    bus.req = 1'b0;
    wait_drain();
    check_output("access_ram_writes", mem_wr_cnt - wr0, exp_wr);
  endtask

  task automatic apply_flush(input int lat, input int exp_wr);
    exp_t e;
    int   wr0;
    e.kind  = 1'b1;
    e.chk   = 1'b0;
    e.rdata = 8'h00;
    e.lat   = lat;
    sb.push_back(e);
    wr0 = mem_wr_cnt;
    bus.flush = 1'b1;
    wait_accept();
    @(negedge clock);
    bus.flush = 1'b0;
    wait_drain();
    check_output("flush_ram_writes", mem_wr_cnt - wr0, exp_wr);
  endtask

  // Called right after reset is dropped at a negedge: four zero writes, then ready in cycle 5.
  task automatic check_init();
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      check_output($sformatf("init_cycle%0d", k), {bus.ready, cache_wren, cache_addr, cache_data},
                   (k <= 4) ? {1'b0, 1'b1, 2'(k - 1), 13'h0000} : {1'b1, 1'b0, 2'b11, 13'h0000});
    end
    for (int i = 0; i < 4; i++) check_output($sformatf("init_line%0d", i), lines[i], 13'h0000);
  endtask

  initial begin
    bus.req   = 1'b0;
    bus.we    = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    bus.flush = 1'b0;
    reset     = 1'b1;
    repeat (3) @(negedge clock);
    check_output("reset_outputs", {bus.ready, bus.ack, bus.flush_done, cache_wren, mem_wren, bus.rdata}, 32'd0);
    reset = 1'b0;
    check_init();

    apply_stimulus(1'b0, 5'h05, 8'h00, 8'hA5, 5, 0);
    check_output("line1_after_fill", lines[1], 13'h11A5);
    apply_stimulus(1'b0, 5'h05, 8'h00, 8'hA5, 3, 0);
    apply_stimulus(1'b1, 5'h05, 8'h3C, 8'h00, 4, 0);
    check_output("line1_after_write", lines[1], 13'h193C);
    apply_stimulus(1'b0, 5'h09, 8'h00, 8'h5A, 6, 1);
    check_output("ram5_writeback", ram[5], 8'h3C);
    check_output("line1_after_evict", lines[1], 13'h125A);
    apply_stimulus(1'b1, 5'h1E, 8'h77, 8'h00, 4, 0);
    check_output("line2_write_miss", lines[2], 13'h1F77);
    apply_stimulus(1'b0, 5'h02, 8'h00, 8'h12, 6, 1);
    check_output("ram1e_writeback", ram[5'h1E], 8'h77);
    apply_stimulus(1'b1, 5'h04, 8'h11, 8'h00, 4, 0);
    apply_stimulus(1'b1, 5'h0B, 8'h22, 8'h00, 4, 0);

    apply_flush(13, 2);
    check_output("ram04_flushed", ram[5'h04], 8'h11);
    check_output("ram0b_flushed", ram[5'h0B], 8'h22);
    check_output("line0_clean", lines[0], 13'h1111);
    check_output("line2_untouched", lines[2], 13'h1012);
    check_output("line3_clean", lines[3], 13'h1222);
    apply_flush(9, 0);
    apply_stimulus(1'b0, 5'h04, 8'h00, 8'h11, 3, 0);

    // Read miss interrupted by reset in FILL; the held request must wait for the new INIT.
    bus.req  = 1'b1;
    bus.we   = 1'b0;
    bus.addr = 5'h15;
    wait_accept();
    repeat (3) @(negedge clock);
    check_output("fill_mem_addr", mem_addr, 5'h15);
    reset = 1'b1;
    @(negedge clock);
    check_output("abort_outputs", {bus.ready, bus.ack, cache_wren, mem_wren, bus.rdata}, 32'd0);
    begin
      exp_t e;
      e.kind  = 1'b0;
      e.chk   = 1'b1;
      e.rdata = 8'h25;
      e.lat   = 5;
      sb.push_back(e);
    end
    reset = 1'b0;
    check_init();
    acc_cyc = cyc;
    @(negedge clock);
    bus.req = 1'b0;
    wait_drain();

    $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
